// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard/stall sequencer
package hazard_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  // Per-stage control bundle; a flush always wins over the matching enable.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
  } ctrl_t;

  localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0,
                                    idex_flush: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0};
  localparam ctrl_t CTRL_RESET  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0,
                                    idex_flush: 1'b1, exmem_en: 1'b0, memwb_en: 1'b0};
  localparam ctrl_t CTRL_NORMAL = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
                                    idex_flush: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high reset
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Count up on inc, holding at all-ones instead of wrapping.
  always_comb begin
    q_d = q_q;
    if (inc && (q_q != '1)) begin
      q_d = q_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - stage enables/flushes for load-use, branch, fetch and data-memory waits
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs1_id,
  input  logic [REG_IDX_W-1:0] rs2_id,
  input  logic                 use_rs1_id,
  input  logic                 use_rs2_id,
  input  logic [REG_IDX_W-1:0] rd_ex,
  input  logic                 memRead_ex,
  input  logic                 regWrite_ex,
  input  logic                 branch_taken_ex,
  input  logic                 imem_ready,
  input  logic                 dmem_req_mem,
  input  logic                 dmem_ready,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 ifid_flush,
  output logic                 idex_en,
  output logic                 idex_flush,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic                 bus_err,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [1:0]           state_o
);

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wd_q, wd_d;
  logic       bus_err_q, bus_err_d;
  logic       lu;
  ctrl_t      run_ctrl;
  ctrl_t      ctrl;

  // Hazards forwarding cannot cover: a load result needed by the very next instruction.
  always_comb begin
    lu = memRead_ex && regWrite_ex && (rd_ex != X0_IDX) &&
         ((use_rs1_id && (rd_ex == rs1_id)) || (use_rs2_id && (rd_ex == rs2_id)));
  end

  // Running-pipeline priority: branch squash, then load-use bubble, then fetch wait.
  always_comb begin
    run_ctrl = CTRL_NORMAL;
    if (branch_taken_ex) begin
      run_ctrl            = CTRL_NORMAL;
      run_ctrl.ifid_flush = 1'b1;
      run_ctrl.idex_flush = 1'b1;
    end else if (lu) begin
      run_ctrl.pc_en      = 1'b0;
      run_ctrl.ifid_en    = 1'b0;
      run_ctrl.idex_flush = 1'b1;
    end else if (!imem_ready) begin
      run_ctrl.pc_en      = 1'b0;
      run_ctrl.ifid_flush = 1'b1;
    end
  end

  // FSM next state, watchdog and Mealy control decode; encoding 3 falls into the RUN branch.
  always_comb begin
    ctrl      = CTRL_FREEZE;
    state_d   = state_q;
    wd_d      = wd_q;
    bus_err_d = bus_err_q;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else begin
      case (state_q)
        MEM_WAIT: begin
          if (dmem_ready) begin
            ctrl    = run_ctrl;
            state_d = RUN;
            wd_d    = '0;
          end else if (wd_q == WD_LAST) begin
            state_d   = ERR;
            bus_err_d = 1'b1;
          end else begin
            wd_d = wd_q + 8'd1;
          end
        end
        ERR: begin
          bus_err_d = 1'b1;
        end
        default: begin
          wd_d = '0;
          if (dmem_req_mem && !dmem_ready) begin
            state_d = MEM_WAIT;
          end else begin
            ctrl    = run_ctrl;
            state_d = RUN;
          end
        end
      endcase
    end
  end

  // State, watchdog and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wd_q      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign ifid_en    = ctrl.ifid_en;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_en    = ctrl.idex_en;
  assign idex_flush = ctrl.idex_flush;
  assign exmem_en   = ctrl.exmem_en;
  assign memwb_en   = ctrl.memwb_en;
  assign bus_err    = bus_err_q;
  assign state_o    = state_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(~ctrl.pc_en),
    .q  (stall_cnt)
  );

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencer for the 5-stage RV32I core. It generates per-stage enables and flushes for load-use hazards, taken-branch squashes, instruction-fetch waits and multi-cycle data-memory waits.
- Sits beside forwardingUnit. That unit resolves EX/MEM and MEM/WB RAW hazards by bypass; this block covers the hazards bypass cannot fix.
- Includes a data-memory wait watchdog and a stall-cycle performance counter.

Parameters:
- TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before bus error; legal range 2..255.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous reset, active-high
- rs1_id  in  5  ID-stage source register 1
- rs2_id  in  5  ID-stage source register 2
- use_rs1_id  in  1  ID instruction reads rs1
- use_rs2_id  in  1  ID instruction reads rs2
- rd_ex  in  5  EX-stage destination register
- memRead_ex  in  1  EX instruction is a load
- regWrite_ex  in  1  EX instruction writes the register file
- branch_taken_ex  in  1  EX resolved a taken branch or jump
- imem_ready  in  1  instruction word valid this cycle
- dmem_req_mem  in  1  MEM stage has an active load or store
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC register update
- ifid_en  out  1  IF/ID register load
- ifid_flush  out  1  IF/ID loads a bubble (NOP)
- idex_en  out  1  ID/EX register load
- idex_flush  out  1  ID/EX loads a bubble
- exmem_en  out  1  EX/MEM register load
- memwb_en  out  1  MEM/WB register load
- bus_err  out  1  sticky watchdog error
- stall_cnt  out  CNT_W  saturating count of stalled cycles
- state_o  out  2  current FSM state, for debug

Behaviour:
- Registered: state, watchdog counter, bus_err and stall_cnt, all updated on the rising edge of clk.
- Combinational: all enable and flush outputs are a same-cycle (Mealy) decode of the registered state and the current inputs.
- While rst=1:
  - Enables: pc_en, ifid_en, idex_en, exmem_en and memwb_en are all 0.
  - Flushes: ifid_flush=1, idex_flush=1.
  - Registers at the next edge: state=RUN, bus_err=0, stall_cnt=0, watchdog=0.
  - A reset asserted mid-operation overrides any state, including ERR.
- Flush takes precedence over enable: when flush=1, the register loads a bubble regardless of its enable.
- FSM states: RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2. Encoding 3 is unreachable and must decode as RUN.
- RUN transitions:
  - dmem_req_mem=1 and dmem_ready=0 → MEM_WAIT. In that same cycle all enables are 0 and both flushes are 0 (full freeze).
  - Otherwise stay in RUN, with controls decided by the priority list below.
- RUN priority, highest first:
  1. Branch: branch_taken_ex=1 → pc_en=1, ifid_flush=1, idex_flush=1, all other enables 1. This overrides load-use and imem wait.
  2. Load-use: lu = memRead_ex & regWrite_ex & (rd_ex!=0) & ((use_rs1_id & rd_ex==rs1_id) | (use_rs2_id & rd_ex==rs2_id)). When lu=1 → pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1. The stall lasts exactly one cycle; next cycle EX holds the bubble and the forwardingUnit supplies the load value from MEM/WB.
  3. Fetch wait: imem_ready=0 → pc_en=0, ifid_flush=1, all downstream enables 1.
  4. Otherwise: all enables 1, all flushes 0.
- MEM_WAIT:
  - Full freeze: all enables 0, flushes 0, watchdog increments every cycle.
  - Branch and load-use conditions are ignored; they are held in the frozen registers and evaluated on return to RUN.
  - dmem_ready=1 → RUN. That cycle decodes as RUN priority with the memory access complete, and the watchdog clears.
  - Watchdog == TIMEOUT-1 with dmem_ready=0 → ERR; bus_err←1. If dmem_ready=1 on that same cycle, it wins and the FSM goes to RUN.
- ERR: full freeze, bus_err=1; left only by rst.
- stall_cnt: increments on every non-reset cycle where pc_en=0. Saturates at 2^CNT_W-1 and never wraps.

Decomposition:
- Package hazard_pkg:
  - state encodings RUN, MEM_WAIT, ERR
  - register-index width constant (5)
  - x0 index constant
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, q), instantiated for stall_cnt.
- The watchdog stays inline, since its clear and compare are state-dependent.

Test Plan:
- Load-use: ld x5 in EX (memRead_ex=1, regWrite_ex=1, rd_ex=5), ID rs1_id=5 with use_rs1_id=1 → one cycle of pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1; stall_cnt=1. Repeat with rd_ex=0 → no stall.
- Branch plus load-use in the same cycle → ifid_flush=1, idex_flush=1, pc_en=1; no stall cycle; stall_cnt unchanged.
- dmem_req_mem=1 with dmem_ready low for 3 cycles, then high → state_o=1 for 3 cycles with all enables 0; return to RUN; bus_err=0; stall_cnt=3.
- TIMEOUT=4, dmem_ready held low → ERR entered after 4 frozen cycles, bus_err=1 sticky; dmem_ready rising afterwards has no effect; rst=1 for one cycle → state_o=0, bus_err=0, stall_cnt=0.
- imem_ready=0 for 2 cycles → pc_en=0 and ifid_flush=1 on both cycles; idex_en, exmem_en and memwb_en stay 1.
- CNT_W=3 with 10 stall cycles → stall_cnt saturates at 7 and does not wrap.
